// File: rtl/hamming_secded_codec_pipe.sv
// Two-stage pipelined Hamming SECDED encoder/decoder with valid/ready handshaking
// and saturating counters for delivered single-corrected and double-detected results.
module hamming_secded_codec_pipe #(
    parameter int DATA_W = 8,
    parameter int R      = 4,
    parameter int CNT_W  = 16,
    localparam int CW    = DATA_W + R + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_op,
    input  logic [CW-1:0]     in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_op,
    output logic [CW-1:0]     out_data,
    output logic [R-1:0]      out_syndrome,
    output logic              out_sec,
    output logic              out_ded,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_sec,
    output logic [CNT_W-1:0]  cnt_ded
);

    // Positions (1..CW-1) whose index has bit k set; bit p-1 of the mask is position p.
    function automatic logic [CW-2:0] pos_mask(input int k);
        logic [CW-2:0] m;
        m = '0;
        for (int p = 1; p < CW; p++) begin
            m[p-1] = ((p >> k) & 1) == 1;
        end
        return m;
    endfunction

    // Place data bits on the non-power-of-two positions, d0 at the lowest one.
    function automatic logic [CW-2:0] spread_data(input logic [DATA_W-1:0] d);
        logic [CW-2:0] w;
        int j;
        w = '0;
        j = 0;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p-1] = d[j];
                j++;
            end
        end
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input logic [CW-1:0] w);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = w[p-1];
                j++;
            end
        end
        return d;
    endfunction

    logic              s1_valid_reg;
    logic              s1_op_reg;
    logic [CW-1:0]     s1_word_reg;
    logic [R-1:0]      s1_syn_reg;
    logic              s1_ov_reg;

    logic              out_valid_reg;
    logic              out_op_reg;
    logic [CW-1:0]     out_data_reg;
    logic [R-1:0]      out_syn_reg;
    logic              out_sec_reg;
    logic              out_ded_reg;
    logic [CNT_W-1:0]  cnt_sec_reg;
    logic [CNT_W-1:0]  cnt_ded_reg;

    logic              s2_advance;
    logic              s1_advance;
    logic              in_fire;
    logic              out_fire;

    logic [CW-2:0]     in_spread;
    logic [R-1:0]      enc_chk;
    logic [R-1:0]      dec_syn;
    logic [CW-1:0]     s1_word_next;

    assign s2_advance = !out_valid_reg || out_ready;
    assign s1_advance = s1_valid_reg && s2_advance;
    assign in_ready   = !s1_valid_reg || s1_advance;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid_reg && out_ready;

    assign in_spread = spread_data(in_data[DATA_W-1:0]);

    // Check bits and syndrome share the same position masks.
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_parity
            localparam logic [CW-2:0] MASK = pos_mask(gi);
            assign enc_chk[gi] = ^(in_spread & MASK);
            assign dec_syn[gi] = ^(in_data[CW-2:0] & MASK);
        end
    endgenerate

    always_comb begin
        logic [CW-2:0] low;
        low = in_spread;
        for (int k = 0; k < R; k++) begin
            low[(1 << k) - 1] = enc_chk[k];
        end
        s1_word_next = in_op ? in_data : {^low, low};
    end

    // Stage 2: classify and correct.
    logic [CW-1:0] s2_data_next;
    logic [R-1:0]  s2_syn_next;
    logic          s2_sec_next;
    logic          s2_ded_next;

    always_comb begin
        logic [CW-1:0] corrected;
        corrected    = s1_word_reg;
        s2_data_next = s1_word_reg;
        s2_syn_next  = '0;
        s2_sec_next  = 1'b0;
        s2_ded_next  = 1'b0;
        if (s1_op_reg) begin
            s2_syn_next = s1_syn_reg;
            if (s1_ov_reg) begin
                if (int'(s1_syn_reg) <= CW - 1) begin
                    s2_sec_next = 1'b1;
                    for (int p = 1; p < CW; p++) begin
                        if (int'(s1_syn_reg) == p) begin
                            corrected[p-1] = ~corrected[p-1];
                        end
                    end
                end else begin
                    s2_ded_next = 1'b1;
                end
            end else if (s1_syn_reg != '0) begin
                s2_ded_next = 1'b1;
            end
            s2_data_next = '0;
            s2_data_next[DATA_W-1:0] = extract_data(corrected);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= 1'b0;
            s1_word_reg  <= '0;
            s1_syn_reg   <= '0;
            s1_ov_reg    <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_fire) begin
                s1_op_reg   <= in_op;
                s1_word_reg <= s1_word_next;
                s1_syn_reg  <= in_op ? dec_syn : '0;
                s1_ov_reg   <= in_op & (^in_data);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_op_reg    <= 1'b0;
            out_data_reg  <= '0;
            out_syn_reg   <= '0;
            out_sec_reg   <= 1'b0;
            out_ded_reg   <= 1'b0;
        end else if (s2_advance) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_op_reg   <= s1_op_reg;
                out_data_reg <= s2_data_next;
                out_syn_reg  <= s2_syn_next;
                out_sec_reg  <= s2_sec_next;
                out_ded_reg  <= s2_ded_next;
            end
        end
    end

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_sec_reg <= '0;
            cnt_ded_reg <= '0;
        end else if (cnt_clr) begin
            cnt_sec_reg <= '0;
            cnt_ded_reg <= '0;
        end else if (out_fire) begin
            if (out_sec_reg && (cnt_sec_reg != '1)) begin
                cnt_sec_reg <= cnt_sec_reg + CNT_ONE;
            end
            if (out_ded_reg && (cnt_ded_reg != '1)) begin
                cnt_ded_reg <= cnt_ded_reg + CNT_ONE;
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_op       = out_op_reg;
    assign out_data     = out_data_reg;
    assign out_syndrome = out_syn_reg;
    assign out_sec      = out_sec_reg;
    assign out_ded      = out_ded_reg;
    assign cnt_sec      = cnt_sec_reg;
    assign cnt_ded      = cnt_ded_reg;

endmodule

// File: tb/tb_hamming_secded_codec_pipe.sv
// Directed bench for the SECDED codec: vector table for encode/decode results plus
// hand-written stall, counter saturation/clear and mid-stream reset sequences.
module tb_hamming_secded_codec_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [12:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_op;
    logic [12:0] out_data;
    logic [3:0]  out_syndrome;
    logic        out_sec;
    logic        out_ded;
    logic        cnt_clr;
    logic [15:0] cnt_sec;
    logic [15:0] cnt_ded;

    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_op;
    logic [12:0] s_out_data;
    logic [3:0]  s_out_syndrome;
    logic        s_out_sec;
    logic        s_out_ded;
    logic [1:0]  s_cnt_sec;
    logic [1:0]  s_cnt_ded;

    int checks = 0;
    int errors = 0;

    hamming_secded_codec_pipe #(.DATA_W(8), .R(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_data(out_data),
        .out_syndrome(out_syndrome), .out_sec(out_sec), .out_ded(out_ded),
        .cnt_clr(cnt_clr), .cnt_sec(cnt_sec), .cnt_ded(cnt_ded)
    );

    hamming_secded_codec_pipe #(.DATA_W(8), .R(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_op(in_op), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_op(s_out_op), .out_data(s_out_data),
        .out_syndrome(s_out_syndrome), .out_sec(s_out_sec), .out_ded(s_out_ded),
        .cnt_clr(cnt_clr), .cnt_sec(s_cnt_sec), .cnt_ded(s_cnt_ded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [12:0] din;
        logic [12:0] dout;
        logic [3:0]  syn;
        logic        sec;
        logic        ded;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_op    = v.op;
        in_data  = v.din;
        #1;
        check("in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        check("out_valid_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("out_valid_lat2", {31'd0, out_valid}, 32'd1);
        check("out_op", {31'd0, out_op}, {31'd0, v.op});
        check("out_data", {19'd0, out_data}, {19'd0, v.dout});
        check("out_syndrome", {28'd0, out_syndrome}, {28'd0, v.syn});
        check("out_sec", {31'd0, out_sec}, {31'd0, v.sec});
        check("out_ded", {31'd0, out_ded}, {31'd0, v.ded});
        $display("vec op=%0d in=0x%03h -> out=0x%03h syn=%0d sec=%0d ded=%0d",
                 v.op, v.din, out_data, out_syndrome, out_sec, out_ded);
    endtask

    initial begin
        int n_sec;
        int n_ded;
        int sent;
        logic [12:0] words[4];
        logic [12:0] exp_d[4];
        logic [12:0] rx[$];

        rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_data = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {19'd0, out_data}, 32'd0);
        check("rst_cnt_sec", {16'd0, cnt_sec}, 32'd0);
        check("rst_cnt_ded", {16'd0, cnt_ded}, 32'd0);

        //        op    din       dout      syn   sec   ded
        vecs[0]  = '{1'b0, 13'h00A5, 13'h0A27, 4'd0,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 13'h0A27, 13'h00A5, 4'd0,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 13'h0A07, 13'h00A5, 4'd6,  1'b1, 1'b0};
        vecs[3]  = '{1'b1, 13'h1A27, 13'h00A5, 4'd0,  1'b1, 1'b0};
        vecs[4]  = '{1'b1, 13'h0A24, 13'h00A5, 4'd3,  1'b0, 1'b1};
        vecs[5]  = '{1'b1, 13'h0AAE, 13'h00A5, 4'd13, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 13'h00FF, 13'h0F77, 4'd0,  1'b0, 1'b0};
        vecs[7]  = '{1'b0, 13'h1F00, 13'h0000, 4'd0,  1'b0, 1'b0};
        vecs[8]  = '{1'b1, 13'h0777, 13'h00FF, 4'd12, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 13'h0A26, 13'h00A5, 4'd1,  1'b1, 1'b0};
        vecs[10] = '{1'b1, 13'h0000, 13'h0000, 4'd0,  1'b0, 1'b0};
        vecs[11] = '{1'b1, 13'h0224, 13'h0025, 4'd15, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 13'h0F77, 13'h00FF, 4'd0,  1'b0, 1'b0};

        n_sec = 0;
        n_ded = 0;
        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
            if (vecs[i].sec) n_sec++;
            if (vecs[i].ded) n_ded++;
        end
        @(posedge clk); #1;
        check("cnt_sec_table", {16'd0, cnt_sec}, n_sec);
        check("cnt_ded_table", {16'd0, cnt_ded}, n_ded);
        check("sat_cnt_sec_table", {30'd0, s_cnt_sec}, (n_sec > 3) ? 3 : n_sec);
        check("sat_cnt_ded_table", {30'd0, s_cnt_ded}, (n_ded > 3) ? 3 : n_ded);

        // Stream 4 words against a 5-cycle output stall.
        words = '{13'h0A27, 13'h0F77, 13'h0000, 13'h0224};
        exp_d = '{13'h00A5, 13'h00FF, 13'h0000, 13'h0025};
        sent = 0;
        rx.delete();
        in_op = 1'b1;
        for (int cyc = 0; cyc < 40 && rx.size() < 4; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 5) begin
                check("stall_accepted", sent, 2);
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                check("stall_out_valid", {31'd0, out_valid}, 32'd1);
                check("stall_out_data", {19'd0, out_data}, 32'h00A5);
            end
            out_ready = (cyc >= 5);
            in_valid  = (sent < 4);
            if (sent < 4) in_data = words[sent];
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                rx.push_back(out_data);
                $display("stream out=0x%03h", out_data);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", rx.size(), 4);
        for (int i = 0; i < rx.size() && i < 4; i++) begin
            check("stream_order", {19'd0, rx[i]}, {19'd0, exp_d[i]});
        end

        // Counter clear, saturation, and clear winning over a same-cycle SEC delivery.
        @(posedge clk); #1 cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        check("clr_cnt_sec", {16'd0, cnt_sec}, 32'd0);
        check("clr_sat_cnt_ded", {30'd0, s_cnt_ded}, 32'd0);
        for (int i = 0; i < 5; i++) run_vec(vecs[2]);
        @(posedge clk); #1;
        check("sat_cnt_sec", {30'd0, s_cnt_sec}, 32'd3);
        check("cnt_sec_5", {16'd0, cnt_sec}, 32'd5);
        in_valid = 1'b1; in_op = 1'b1; in_data = 13'h0A07;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        check("clr_race_sec", {31'd0, out_sec}, 32'd1);
        cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        check("clr_race_cnt_sec", {16'd0, cnt_sec}, 32'd0);
        check("clr_race_sat_cnt_sec", {30'd0, s_cnt_sec}, 32'd0);
        $display("counters after clear race: cnt_sec=%0d sat=%0d", cnt_sec, s_cnt_sec);

        // Reset while a result is waiting at the output.
        run_vec(vecs[2]);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 1'b1; in_data = 13'h0A27;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_cnt_sec", {16'd0, cnt_sec}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_out_data", {19'd0, out_data}, 32'd0);
        check("async_rst_cnt_sec", {16'd0, cnt_sec}, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        run_vec(vecs[0]);
        run_vec(vecs[5]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
